// File: rtl/mem_arbiter.sv
// Two-requester (CPU/host) arbiter for a single-port synchronous data memory.
// Optional `ARB_ROUND_ROBIN_EN: ties go to the requester not granted last; otherwise CPU wins.
module mem_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ack,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       host_ack,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StGrant, StAck} state_e;

  localparam logic OwnerCpu  = 1'b0;
  localparam logic OwnerHost = 1'b1;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0] host_rdata_q, host_rdata_d;
  logic       cpu_ack_q, cpu_ack_d;
  logic       host_ack_q, host_ack_d;
  logic       grant_host;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Tie goes to whoever did not win the previous grant.
  assign grant_host = host_req & (~cpu_req | (last_q == OwnerCpu));

  always_comb begin
    last_d = last_q;
    if (state_q == StIdle && (cpu_req || host_req)) begin
      last_d = grant_host;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= OwnerHost;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign grant_host = host_req & ~cpu_req;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (cpu_req || host_req) begin
          owner_d = grant_host ? OwnerHost : OwnerCpu;
          we_d    = grant_host ? host_we : cpu_we;
          addr_d  = grant_host ? host_addr : cpu_addr;
          wdata_d = grant_host ? host_wdata : cpu_wdata;
          state_d = StGrant;
        end
      end
      StGrant: state_d = StAck;
      StAck: begin
        // Ack and read data are registered together so rdata is valid while ack is high.
        if (owner_q == OwnerHost) begin
          host_ack_d = 1'b1;
          if (!we_q) host_rdata_d = mem_rdata;
        end else begin
          cpu_ack_d = 1'b1;
          if (!we_q) cpu_rdata_d = mem_rdata;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnerCpu;
      we_q         <= 1'b0;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      cpu_rdata_q  <= 8'h00;
      host_rdata_q <= 8'h00;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      host_ack_q   <= host_ack_d;
    end
  end

  // Latched address/data drive the memory directly and hold between accesses.
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = (state_q == StGrant) & we_q;
  assign busy       = (state_q != StIdle);
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign host_ack   = host_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;

  logic       clk, reset;
  logic       cpu_req, cpu_we, host_req, host_we;
  logic [7:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic [7:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       cpu_ack, host_ack, mem_we, busy;
  logic [7:0] mem [256];
  int         n_vec, n_err;

  mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ack   (host_ack),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    step; step;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if ({cpu_ack, host_ack, mem_we} !== 3'b000) begin
      n_err++; $display("FAIL rst_strobes got %b want 000", {cpu_ack, host_ack, mem_we}); end
    n_vec++; if ({mem_addr, mem_wdata} !== 16'h0000) begin
      n_err++; $display("FAIL rst_mem_bus got %h want 0000", {mem_addr, mem_wdata}); end
    n_vec++; if ({cpu_rdata, host_rdata} !== 16'h0000) begin
      n_err++; $display("FAIL rst_rdata got %h want 0000", {cpu_rdata, host_rdata}); end
    reset = 1'b1;
    step;
  endtask

  task automatic test_cpu_write;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
    step;  // GRANT
    n_vec++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h10, 8'hA5}) begin
      n_err++; $display("FAIL wr_grant_bus got %b/%h/%h want 1/10/a5", mem_we, mem_addr, mem_wdata); end
    n_vec++; if ({busy, cpu_ack} !== 2'b10) begin
      n_err++; $display("FAIL wr_grant_busy_ack got %b want 10", {busy, cpu_ack}); end
    step;  // ACK
    n_vec++; if ({mem_we, busy, cpu_ack, mem_addr} !== {3'b010, 8'h10}) begin
      n_err++; $display("FAIL wr_ack_state got %b/%h want 010/10", {mem_we, busy, cpu_ack}, mem_addr); end
    step;  // IDLE, ack visible
    n_vec++; if ({cpu_ack, host_ack, busy} !== 3'b100) begin
      n_err++; $display("FAIL wr_ack_pulse got %b want 100", {cpu_ack, host_ack, busy}); end
    cpu_req = 1'b0; cpu_we = 1'b0;
    step;
    n_vec++; if ({cpu_ack, busy} !== 2'b00) begin
      n_err++; $display("FAIL wr_ack_once got %b want 00", {cpu_ack, busy}); end
  endtask

  task automatic test_host_read;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    step;
    n_vec++; if ({mem_we, mem_addr} !== {1'b0, 8'h10}) begin
      n_err++; $display("FAIL rd_grant_bus got %b/%h want 0/10", mem_we, mem_addr); end
    step; step;
    n_vec++; if ({host_ack, cpu_ack, host_rdata} !== {2'b10, 8'hA5}) begin
      n_err++; $display("FAIL rd_host got %b/%h want 10/a5", {host_ack, cpu_ack}, host_rdata); end
    host_req = 1'b0;
    step;
    n_vec++; if (host_ack !== 1'b0) begin n_err++; $display("FAIL rd_host_once got %b want 0", host_ack); end
  endtask

  task automatic test_addr_change;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h5A;
    step;  // GRANT: perturb inputs
    cpu_addr = 8'h30; cpu_wdata = 8'hFF;
    #1;
    n_vec++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h20, 8'h5A}) begin
      n_err++; $display("FAIL chg_bus got %b/%h/%h want 1/20/5a", mem_we, mem_addr, mem_wdata); end
    step; step;
    n_vec++; if (cpu_ack !== 1'b1) begin n_err++; $display("FAIL chg_ack got %b want 1", cpu_ack); end
    cpu_req = 1'b0; cpu_we = 1'b0;
    step;
    cpu_req = 1'b1; cpu_addr = 8'h20;
    step; step; step;
    n_vec++; if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h5A}) begin
      n_err++; $display("FAIL chg_readback got %b/%h want 1/5a", cpu_ack, cpu_rdata); end
    cpu_req = 1'b0;
    step;
    host_req = 1'b1; host_addr = 8'h30;
    step; step; step;
    n_vec++; if ({host_ack, host_rdata, cpu_rdata} !== {1'b1, 8'h00, 8'h5A}) begin
      n_err++; $display("FAIL chg_untouched got %b/%h/%h want 1/00/5a", host_ack, host_rdata, cpu_rdata); end
    host_req = 1'b0;
    step;
  endtask

  task automatic test_tie;
    logic [3:0] exp_host;
    logic [7:0] exp_hrd;
`ifdef ARB_ROUND_ROBIN_EN
    exp_host = 4'b1010; exp_hrd = 8'h5A;
`else
    exp_host = 4'b0000; exp_hrd = 8'h00;
`endif
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    for (int k = 0; k < 4; k++) begin
      step; step;
      n_vec++; if ({cpu_ack, host_ack} !== 2'b00) begin
        n_err++; $display("FAIL tie_noack_%0d got %b want 00", k, {cpu_ack, host_ack}); end
      step;
      n_vec++; if ({cpu_ack, host_ack} !== {~exp_host[k], exp_host[k]}) begin
        n_err++; $display("FAIL tie_winner_%0d got %b want %b", k, {cpu_ack, host_ack},
                          {~exp_host[k], exp_host[k]}); end
    end
    cpu_req = 1'b0; host_req = 1'b0;
    n_vec++; if ({cpu_rdata, host_rdata} !== {8'hA5, exp_hrd}) begin
      n_err++; $display("FAIL tie_rdata got %h/%h want a5/%h", cpu_rdata, host_rdata, exp_hrd); end
    step;
  endtask

  task automatic test_reset_mid_grant;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h77;
    step;
    n_vec++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL mid_grant_we got %b want 1", mem_we); end
    #2 reset = 1'b0;
    #1;
    n_vec++; if ({mem_we, busy, cpu_ack, host_ack} !== 4'b0000) begin
      n_err++; $display("FAIL mid_async_strobes got %b want 0000", {mem_we, busy, cpu_ack, host_ack}); end
    n_vec++; if ({mem_addr, mem_wdata, cpu_rdata, host_rdata} !== 32'h0) begin
      n_err++; $display("FAIL mid_async_data got %h want 00000000",
                        {mem_addr, mem_wdata, cpu_rdata, host_rdata}); end
    step; step;
    n_vec++; if ({cpu_ack, busy} !== 2'b00) begin
      n_err++; $display("FAIL mid_held_noack got %b want 00", {cpu_ack, busy}); end
    reset = 1'b1;
    step;
    n_vec++; if ({busy, mem_we, mem_addr} !== {2'b11, 8'h40}) begin
      n_err++; $display("FAIL mid_restart got %b/%h want 11/40", {busy, mem_we}, mem_addr); end
    step; step;
    n_vec++; if (cpu_ack !== 1'b1) begin n_err++; $display("FAIL mid_restart_ack got %b want 1", cpu_ack); end
    cpu_req = 1'b0; cpu_we = 1'b0;
    step;
    host_req = 1'b1; host_addr = 8'h40;
    step; step; step;
    n_vec++; if ({host_ack, host_rdata} !== {1'b1, 8'h77}) begin
      n_err++; $display("FAIL mid_readback got %b/%h want 1/77", host_ack, host_rdata); end
    host_req = 1'b0;
    step;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset;
    test_cpu_write;
    test_host_read;
    test_addr_change;
    test_tie;
    test_reset_mid_grant;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
